register_file: RTL and testbench



---
 rtl/register_pkg.sv | 15 +
 rtl/register_file_if.sv | 27 ++
 rtl/clear_sequencer.sv | 59 +++++
 rtl/register_file.sv | 64 ++++++
 tb/tb_register_file.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/register_pkg.sv
// Shared constants and state encoding for the register file and its clear sequencer.
package register_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 3;

    localparam logic IDLE  = 1'b0;
    localparam logic CLEAR = 1'b1;

    typedef enum logic {
        StIdle  = IDLE,
        StClear = CLEAR
    } state_e;

endpackage

// File: rtl/register_file_if.sv
// Bus bundle for the register file: write port, two read ports, clear request and busy flag.
interface register_file_if
    import register_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned AddrWidth = DefAddrWidth
);
    logic                 wr_n;
    logic [AddrWidth-1:0] waddr;
    logic [DataWidth-1:0] din;
    logic [AddrWidth-1:0] raddr_a;
    logic [AddrWidth-1:0] raddr_b;
    logic                 clr_n;
    logic [DataWidth-1:0] dout_a;
    logic [DataWidth-1:0] dout_b;
    logic                 busy;

    modport master (
        output wr_n, waddr, din, raddr_a, raddr_b, clr_n,
        input  dout_a, dout_b, busy
    );

    modport slave (
        input  wr_n, waddr, din, raddr_a, raddr_b, clr_n,
        output dout_a, dout_b, busy
    );
endinterface

// File: rtl/clear_sequencer.sv
// Sweep FSM: on a clear request, walks the address space zeroing one entry per falling edge.
module clear_sequencer
    import register_pkg::*;
#(
    parameter int unsigned AddrWidth = DefAddrWidth
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clr_n,
    output logic                 o_clr_en,
    output logic [AddrWidth-1:0] o_clr_addr,
    output logic                 o_busy,
    output logic                 o_idle
);
    localparam int unsigned          Depth   = 2 ** AddrWidth;
    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(Depth - 1);

    state_e               r_state;
    state_e               w_state_next;
    logic [AddrWidth-1:0] r_cnt;
    logic [AddrWidth-1:0] w_cnt_next;

    always_ff @(negedge i_clk) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StIdle: begin
                if (!i_clr_n) begin
                    w_state_next = StClear;
                    w_cnt_next   = '0;
                end
            end
            StClear: begin
                w_cnt_next = r_cnt + 1'b1;
                // Stop on the last index explicitly rather than relying on wrap.
                if (r_cnt == LastIdx) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign o_clr_en   = (r_state == StClear);
    assign o_clr_addr = r_cnt;
    assign o_busy     = (r_state == StClear);
    assign o_idle     = (r_state == StIdle);
endmodule

// File: rtl/register_file.sv
// General-purpose register bank: one write port, two combinational read ports, hardware clear.
// Optional write-through forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module register_file
    import register_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned AddrWidth = DefAddrWidth
) (
    input  logic            i_clk,
    input  logic            i_reset,
    register_file_if.slave  bus
);
    localparam int unsigned Depth = 2 ** AddrWidth;

    logic [DataWidth-1:0] r_mem [Depth];
    logic                 w_clr_en;
    logic [AddrWidth-1:0] w_clr_addr;
    logic                 w_idle;
    logic                 w_we;

    clear_sequencer #(
        .AddrWidth (AddrWidth)
    ) u_clear_sequencer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr_n    (bus.clr_n),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr),
        .o_busy     (bus.busy),
        .o_idle     (w_idle)
    );

    // A clear request on the same edge wins over a write.
    assign w_we = w_idle & ~bus.wr_n & bus.clr_n;

    always_ff @(negedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_we) begin
            r_mem[bus.waddr] <= bus.din;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = w_idle & ~bus.wr_n & i_reset;

    always_comb begin
        bus.dout_a = r_mem[bus.raddr_a];
        bus.dout_b = r_mem[bus.raddr_b];
        if (w_fwd && (bus.raddr_a == bus.waddr)) bus.dout_a = bus.din;
        if (w_fwd && (bus.raddr_b == bus.waddr)) bus.dout_b = bus.din;
    end
`else
    always_comb begin
        bus.dout_a = r_mem[bus.raddr_a];
        bus.dout_b = r_mem[bus.raddr_b];
    end
`endif
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized phase vs a model.
module tb_register_file;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned N  = 8;

    logic clk = 1'b0;
    logic rst_n;

    register_file_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    register_file #(
        .DataWidth (DW),
        .AddrWidth (AW)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: array contents plus sweep position (-1 when not sweeping).
    logic [DW-1:0] m_mem [N];
    int            m_pos = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        logic fwd;
`ifdef REGFILE_BYPASS_EN
        fwd = rst_n && (m_pos < 0) && !bus.wr_n && (a == bus.waddr);
`else
        fwd = 1'b0;
`endif
        return fwd ? bus.din : m_mem[a];
    endfunction

    // Advance the model by the rules for the upcoming falling edge, then take the edge.
    task automatic cyc();
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_mem[i] = '0;
            m_pos = -1;
        end else if (m_pos >= 0) begin
            m_mem[m_pos] = '0;
            m_pos = (m_pos == N - 1) ? -1 : m_pos + 1;
        end else if (!bus.clr_n) begin
            m_pos = 0;
        end else if (!bus.wr_n) begin
            m_mem[bus.waddr] = bus.din;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        bus.wr_n  = 1'b0;
        bus.waddr = AW'(a);
        bus.din   = DW'(d);
        cyc();
        bus.wr_n  = 1'b1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            bus.raddr_a = AW'(i);
            bus.raddr_b = AW'(N - 1 - i);
            #1;
            chk({tag, "_a"}, bus.dout_a, exp_rd(AW'(i)));
            chk({tag, "_b"}, bus.dout_b, exp_rd(AW'(N - 1 - i)));
        end
    endtask

    initial begin
        int cnt;
        rst_n       = 1'b0;
        bus.wr_n    = 1'b1;
        bus.clr_n   = 1'b1;
        bus.waddr   = '0;
        bus.din     = '0;
        bus.raddr_a = '0;
        bus.raddr_b = '0;
        for (int i = 0; i < N; i++) m_mem[i] = 'x;
        cyc();
        rst_n = 1'b1;

        // Reset after junk
        for (int i = 0; i < N; i++) wr(i, $urandom_range(1, 255));
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_busy", bus.busy, 0);
        for (int i = 0; i < N; i++) begin
            bus.raddr_a = AW'(i);
            bus.raddr_b = AW'(i);
            #1;
            chk("rst_a", bus.dout_a, 0);
            chk("rst_b", bus.dout_b, 0);
        end

        // Write / read, including same-address reads
        wr(3, 8'hA5);
        wr(7, 8'h5A);
        bus.raddr_a = 3;
        bus.raddr_b = 7;
        #1;
        chk("wr_a3", bus.dout_a, 8'hA5);
        chk("wr_b7", bus.dout_b, 8'h5A);
        bus.raddr_b = 3;
        #1;
        chk("same_b3", bus.dout_b, 8'hA5);

        // Bypass behaviour before and after the edge
        wr(2, 8'h00);
        bus.wr_n    = 1'b0;
        bus.waddr   = 2;
        bus.din     = 8'h3C;
        bus.raddr_a = 2;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_pre", bus.dout_a, 8'h3C);
`else
        chk("byp_pre", bus.dout_a, 8'h00);
`endif
        cyc();
        bus.wr_n = 1'b1;
        chk("byp_post", bus.dout_a, 8'h3C);

        // Clear sweep
        for (int i = 0; i < N; i++) wr(i, 8'h11 * (i + 1));
        bus.clr_n = 1'b0;
        cyc();
        bus.clr_n = 1'b1;
        cnt = 0;
        while (bus.busy && cnt < 20) begin
            cnt++;
            bus.wr_n = 1'b1;
            if (cnt == 2) begin
                bus.wr_n  = 1'b0;
                bus.waddr = 4;
                bus.din   = 8'hFF;
            end
            if (cnt == 4) begin
                bus.raddr_a = 2;
                bus.raddr_b = 5;
                #1;
                chk("mid_e2", bus.dout_a, 8'h00);
                chk("mid_e5", bus.dout_b, 8'h66);
                bus.raddr_a = 4;
                #1;
                chk("mid_e4", bus.dout_a, 8'h55);
            end
            cyc();
        end
        bus.wr_n = 1'b1;
        chk("busy_len", cnt, N);
        check_all("swept");
        for (int i = 0; i < N; i++) chk("swept_model", m_mem[i], 0);

        // Clear has priority over a same-edge write
        wr(1, 8'h44);
        bus.wr_n  = 1'b0;
        bus.waddr = 1;
        bus.din   = 8'h77;
        bus.clr_n = 1'b0;
        cyc();
        bus.wr_n  = 1'b1;
        bus.clr_n = 1'b1;
        chk("prio_busy", bus.busy, 1);
        bus.raddr_a = 1;
        #1;
        chk("prio_e1_mid", bus.dout_a, 8'h44);
        cnt = 0;
        while (bus.busy && cnt < 20) begin
            cnt++;
            cyc();
        end
        chk("prio_len", cnt, N);
        chk("prio_e1", bus.dout_a, 8'h00);

        // Reset in the middle of a sweep
        for (int i = 0; i < N; i++) wr(i, 8'hEE);
        bus.clr_n = 1'b0;
        cyc();
        bus.clr_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rmid_busy", bus.busy, 0);
        for (int i = 0; i < N; i++) begin
            bus.raddr_a = AW'(i);
            #1;
            chk("rmid_zero", bus.dout_a, 0);
        end
        wr(0, 8'h12);
        bus.raddr_a = 0;
        #1;
        chk("rmid_wr0", bus.dout_a, 8'h12);
        chk("rmid_idle", bus.busy, 0);

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            bus.wr_n    = $urandom_range(0, 1) == 0;
            bus.waddr   = AW'($urandom_range(0, N - 1));
            bus.din     = DW'($urandom);
            bus.raddr_a = AW'($urandom_range(0, N - 1));
            bus.raddr_b = ($urandom_range(0, 3) == 0) ? bus.waddr : AW'($urandom_range(0, N - 1));
            bus.clr_n   = ($urandom_range(0, 19) != 0);
            #1;
            chk("rnd_a", bus.dout_a, exp_rd(bus.raddr_a));
            chk("rnd_b", bus.dout_b, exp_rd(bus.raddr_b));
            cyc();
            chk("rnd_busy", bus.busy, (m_pos >= 0) ? 1 : 0);
        end
        rst_n     = 1'b1;
        bus.wr_n  = 1'b1;
        bus.clr_n = 1'b1;
        #1;
        check_all("rnd_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
